alu_seq: RTL and testbench

Multi-cycle sequencer that drives the 4-bit combinational ALU to execute operations on wide operands, one nibble per cycle.
- Accepts a command over a valid/ready handshake.
- Steps the ALU control inputs (ALUOP, l, c_in) and operand nibbles, chaining carry between passes.
- Accumulates the wide result and flags, then returns them over a second valid/ready handshake.
- Sits between the instruction-decode logic and the single shared ALU instance; it is the only master of that ALU.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_acc.sv | 54 +++++
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
// Opcodes, ALU control encodings and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;

  localparam logic [1:0] ALUOP_ADD  = 2'b10;
  localparam logic [1:0] ALUOP_INC  = 2'b11;
  localparam logic [1:0] ALUOP_PASS = 2'b00;

  localparam logic [1:0] LOG_AND = 2'b00;
  localparam logic [1:0] LOG_OR  = 2'b01;
  localparam logic [1:0] LOG_XOR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPL,
    S_EXEC,
    S_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_acc.sv
// Nibble-indexed operand/result register file plus the chained carry.
// B is rewritten in place during the complement phase of SUB.
module alu_seq_acc
  import alu_pkg::*;
#(
  parameter int NIBBLES = 2,
  localparam int W = 4 * NIBBLES,
  localparam int KW = idx_w(NIBBLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  input  logic [KW-1:0] k,
  input  logic          b_we,
  input  logic          r_we,
  input  logic [3:0]    wdata,
  input  logic          c_in,
  output logic [3:0]    a_nib,
  output logic [3:0]    b_nib,
  output logic          carry,
  output logic [W-1:0]  result
);

  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;
  logic [NIBBLES-1:0][3:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= b_in;
      r_q   <= '0;
      carry <= 1'b0;
    end else begin
      if (b_we) b_q[k] <= wdata;
      if (r_we) begin
        r_q[k] <= wdata;
        carry  <= c_in;
      end
    end
  end

  assign a_nib  = a_q[k];
  assign b_nib  = b_q[k];
  assign result = r_q;

endmodule

// File: rtl/alu_seq.sv
// Sequencer driving a shared 4-bit ALU over wide operands,
// one nibble per cycle, with request/response handshakes.
module alu_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 2,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic         rsp_sign,
  output logic         rsp_err,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_cin,
  output logic [1:0]   alu_op,
  output logic         alu_l,
  input  logic [3:0]   alu_r,
  input  logic         alu_cout
);

  localparam int KW = idx_w(NIBBLES);
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_t        state;
  logic [2:0]    op;
  logic [KW-1:0] k;
  logic          err;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic          carry;
  logic [W-1:0]  result;
  logic          accept;
  logic          logic_op;
  logic          first;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_ready & req_valid;
  assign first     = (k == '0);
  assign logic_op  = (op == OP_AND) | (op == OP_OR)
                   | (op == OP_XOR);

  alu_seq_acc #(.NIBBLES(NIBBLES)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .a_in   (req_a),
    .b_in   (req_b),
    .k      (k),
    .b_we   (state == S_COMPL),
    .r_we   (state == S_EXEC),
    .wdata  (alu_r),
    .c_in   (logic_op ? 1'b0 : alu_cout),
    .a_nib  (a_nib),
    .b_nib  (b_nib),
    .carry  (carry),
    .result (result)
  );

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_op  = 2'b00;
    alu_l   = 1'b0;
    unique case (1'b1)
      state == S_COMPL: begin
        alu_l  = 1'b1;
        alu_op = LOG_XOR;
        alu_a  = b_nib;
        alu_b  = 4'hF;
      end
      state == S_EXEC: begin
        alu_a = a_nib;
        unique case (op)
          OP_ADD: begin
            alu_op  = ALUOP_ADD;
            alu_b   = b_nib;
            alu_cin = first ? 1'b0 : carry;
          end
          OP_SUB: begin
            alu_op  = ALUOP_ADD;
            alu_b   = b_nib;
            alu_cin = first ? 1'b1 : carry;
          end
          OP_INC: begin
            alu_op  = first ? ALUOP_INC : ALUOP_PASS;
            alu_cin = first ? 1'b0 : carry;
          end
          OP_AND: begin
            alu_l  = 1'b1;
            alu_op = LOG_AND;
            alu_b  = b_nib;
          end
          OP_OR: begin
            alu_l  = 1'b1;
            alu_op = LOG_OR;
            alu_b  = b_nib;
          end
          OP_XOR: begin
            alu_l  = 1'b1;
            alu_op = LOG_XOR;
            alu_b  = b_nib;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op         <= OP_ADD;
      k          <= '0;
      err        <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_sign   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          op  <= req_op;
          k   <= '0;
          err <= 1'b0;
          unique case (1'b1)
            req_op == OP_SUB: state <= S_COMPL;
            req_op > OP_INC: begin
              err   <= 1'b1;
              state <= S_DONE;
            end
            default: state <= S_EXEC;
          endcase
        end
        S_COMPL: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_EXEC;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_EXEC: begin
          if (k == K_LAST) state <= S_DONE;
          else k <= k + 1'b1;
        end
        S_DONE: begin
          // First DONE cycle latches the response; later cycles wait for the consumer.
          if (!rsp_valid) begin
            rsp_valid  <= 1'b1;
            rsp_result <= result;
            rsp_carry  <= carry;
            rsp_zero   <= ~|result;
            rsp_sign   <= result[W-1];
            rsp_err    <= err;
          end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_err    <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 4-bit ALU attached.
// Vector table plus backpressure and reset-abort sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = 3'b000;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_sign;
  logic         rsp_err;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic [1:0]   alu_op;
  logic         alu_l;
  logic [3:0]   alu_r;
  logic         alu_cout;
  logic [4:0]   alu_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.NIBBLES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_sign   (rsp_sign),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_op     (alu_op),
    .alu_l      (alu_l),
    .alu_r      (alu_r),
    .alu_cout   (alu_cout)
  );

  // Reference 4-bit ALU
  always_comb begin
    alu_s = '0;
    if (alu_l) begin
      case (alu_op)
        2'b00:   alu_s = {1'b0, alu_a & alu_b};
        2'b01:   alu_s = {1'b0, alu_a | alu_b};
        2'b10:   alu_s = {1'b0, alu_a ^ alu_b};
        default: alu_s = '0;
      endcase
    end else begin
      case (alu_op)
        2'b10:   alu_s = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
        2'b11:   alu_s = 5'(alu_a) + 5'd1 + 5'(alu_cin);
        2'b00:   alu_s = 5'(alu_a) + 5'(alu_cin);
        default: alu_s = '0;
      endcase
    end
    alu_r    = alu_s[3:0];
    alu_cout = alu_s[4];
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         s;
    logic         e;
    int           lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_bus();
    return 32'({alu_a, alu_b, alu_cin, alu_op, alu_l});
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output bit busy_ok,
                          output bit quiet);
    lat     = 0;
    busy_ok = 1'b1;
    quiet   = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (req_ready) busy_ok = 1'b0;
      if (alu_bus() != 0) quiet = 1'b0;
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("hs_valid_low", 32'(rsp_valid), 32'd0);
    check("hs_ready_high", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit quiet;
    bit seen;

    vecs[0]  = '{OP_ADD, 8'h3A, 8'hC9, 8'h03, 1, 0, 0, 0, 3};
    vecs[1]  = '{OP_SUB, 8'h50, 8'h51, 8'hFF, 0, 0, 1, 0, 5};
    vecs[2]  = '{OP_SUB, 8'h51, 8'h51, 8'h00, 1, 1, 0, 0, 5};
    vecs[3]  = '{OP_INC, 8'hFF, 8'h5A, 8'h00, 1, 1, 0, 0, 3};
    vecs[4]  = '{OP_XOR, 8'hF0, 8'h0F, 8'hFF, 0, 0, 1, 0, 3};
    vecs[5]  = '{OP_AND, 8'h3C, 8'h0F, 8'h0C, 0, 0, 0, 0, 3};
    vecs[6]  = '{OP_OR,  8'hA0, 8'h05, 8'hA5, 0, 0, 1, 0, 3};
    vecs[7]  = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1, 1, 0, 0, 3};
    vecs[8]  = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 0, 0, 1, 0, 5};
    vecs[9]  = '{3'b110, 8'h12, 8'h34, 8'h00, 0, 1, 0, 1, 1};
    vecs[10] = '{3'b111, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 1, 1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_flags", 32'({rsp_carry, rsp_zero, rsp_sign, rsp_err}), 32'd0);
    check("rst_alu", alu_bus(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp(lat, busy_ok, quiet);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].res));
      check($sformatf("v%0d_carry", i), 32'(rsp_carry), 32'(vecs[i].c));
      check($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].z));
      check($sformatf("v%0d_sign", i), 32'(rsp_sign), 32'(vecs[i].s));
      check($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].e));
      check($sformatf("v%0d_busy", i), 32'(busy_ok), 32'd1);
      if (vecs[i].e) check($sformatf("v%0d_alu_quiet", i), 32'(quiet), 32'd1);
      handshake();
    end

    // Backpressure, then a request held across the handshake edge
    do_op(OP_ADD, 8'h12, 8'h34);
    wait_rsp(lat, busy_ok, quiet);
    check("bp_latency", 32'(lat), 32'd3);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", 32'(rsp_result), 32'h46);
      check("bp_flags", 32'({rsp_carry, rsp_zero, rsp_sign, rsp_err}), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_ADD;
    req_a     = 8'h01;
    req_b     = 8'h01;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("bp_hs_valid", 32'(rsp_valid), 32'd0);
    check("bp_no_early_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp_accept_next", 32'(req_ready), 32'd0);
    wait_rsp(lat, busy_ok, quiet);
    check("bp2_latency", 32'(lat), 32'd3);
    check("bp2_result", 32'(rsp_result), 32'h02);
    handshake();

    // Reset during the complement phase of SUB
    do_op(OP_SUB, 8'h50, 8'h51);
    @(negedge clk);
    check("abort_in_compl", 32'(alu_l), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_alu", alu_bus(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);

    do_op(OP_ADD, 8'h3A, 8'hC9);
    wait_rsp(lat, busy_ok, quiet);
    check("post_abort_latency", 32'(lat), 32'd3);
    check("post_abort_result", 32'(rsp_result), 32'h03);
    check("post_abort_carry", 32'(rsp_carry), 32'd1);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
